// File: rtl/iecdrv_rom_sched.sv
// iecdrv_rom_sched
//   Round-robin scheduler that shares one drive-ROM read port among NDR
//   emulated IEC drives. Each round, opened by round_start, gives every
//   enabled drive exactly one fetch. The returned byte is latched per drive
//   and announced with a one-cycle drv_valid pulse. A drive still waiting
//   when the next round opens gets its sticky ovr bit set.
//
// Ports
//   clk, reset_n     16 MHz clock, asynchronous active-low reset
//   round_start      one-cycle pulse opening a fetch round
//   drv_en           per-drive participation mask, sampled on round_start
//   drv_addr         per-drive CPU address, drive i at [i*AW +: AW]
//   drv_rom          per-drive ROM image select, drive i at [i*RSW +: RSW]
//   size_mask        per-image address mask, image k at [k*AW +: AW]
//   rom_addr/rom_sel registered shared ROM address / image select
//   rom_q            ROM data, valid RD_LAT cycles after rom_addr/rom_sel
//   drv_data         per-drive fetched byte, held until the next fetch
//   drv_valid        per-drive one-cycle pulse when drv_data updates
//   ovr, ovr_clr     sticky overrun flags and their clear (set wins)
//
// Handshake: there is no back-pressure. A request issued at edge E is
// answered at edge E+RD_LAT+1, where rom_q is sampled into drv_data and
// drv_valid is high for exactly the following cycle.
module iecdrv_rom_sched #(
  parameter int NDR    = 4,
  parameter int AW     = 15,
  parameter int NROM   = 4,
  parameter int RD_LAT = 1,
  localparam int RSW   = (NROM > 1) ? $clog2(NROM) : 1,
  localparam int PW    = (NDR > 1) ? $clog2(NDR) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              round_start,
  input  logic [NDR-1:0]    drv_en,
  input  logic [NDR*AW-1:0] drv_addr,
  input  logic [NDR*RSW-1:0] drv_rom,
  input  logic [NROM*AW-1:0] size_mask,
  output logic [AW-1:0]     rom_addr,
  output logic [RSW-1:0]    rom_sel,
  input  logic [7:0]        rom_q,
  output logic [NDR*8-1:0]  drv_data,
  output logic [NDR-1:0]    drv_valid,
  output logic [NDR-1:0]    ovr,
  input  logic              ovr_clr
);

  logic [NDR-1:0]             pend_q, pend_d;
  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [RD_LAT:0]            tag_vld_q, tag_vld_d;
  logic [RD_LAT:0][PW-1:0]    tag_idx_q, tag_idx_d;
  logic [NDR-1:0]             ovr_q, ovr_d;
  logic [AW-1:0]              rom_addr_q, rom_addr_d;
  logic [RSW-1:0]             rom_sel_q, rom_sel_d;
  logic [NDR*8-1:0]           drv_data_q, drv_data_d;
  logic [NDR-1:0]             drv_valid_q, drv_valid_d;

  logic [PW-1:0]  scan_base;
  logic           iss_vld;
  logic [PW-1:0]  iss_idx;
  logic [RSW-1:0] iss_rom;
  logic [AW-1:0]  iss_mask;
  logic [AW-1:0]  iss_addr;
  logic [NDR-1:0] iss_oh;
  logic [NDR-1:0] pend_left;
  int             scan_j;

  // rr_ptr has already advanced on the round_start that opened the current
  // round, so the round's first-priority drive is the pointer minus one.
  // This makes the first round after reset start at drive 0.
  always_comb begin
    scan_base = (rr_ptr_q == '0) ? PW'(NDR - 1) : rr_ptr_q - 1'b1;
    iss_vld   = 1'b0;
    iss_idx   = '0;
    scan_j    = 0;
    // Walk downward so the last hit written is the closest to scan_base.
    for (int k = NDR - 1; k >= 0; k--) begin
      scan_j = (int'(scan_base) + k) % NDR;
      if (pend_q[scan_j]) begin
        iss_vld = 1'b1;
        iss_idx = PW'(scan_j);
      end
    end
  end

  // Address of the selected drive; out-of-range image selects fold onto the
  // implemented masks while rom_sel keeps the raw value (open bus at the ROM).
  always_comb begin
    iss_rom  = drv_rom[int'(iss_idx) * RSW +: RSW];
    iss_mask = size_mask[(int'(iss_rom) % NROM) * AW +: AW];
    iss_addr = drv_addr[int'(iss_idx) * AW +: AW] & iss_mask;
    iss_oh   = iss_vld ? (NDR'(1) << iss_idx) : '0;
  end

  always_comb begin
    // The drive issued this edge is no longer pending, so it cannot be
    // flagged even when round_start arrives on the same edge.
    pend_left = pend_q & ~iss_oh;
    pend_d    = round_start ? drv_en : pend_left;

    rr_ptr_d = rr_ptr_q;
    if (round_start) begin
      rr_ptr_d = (int'(rr_ptr_q) == NDR - 1) ? '0 : rr_ptr_q + 1'b1;
    end

    ovr_d = (ovr_q & ~{NDR{ovr_clr}}) | (round_start ? pend_left : '0);

    rom_addr_d = iss_vld ? iss_addr : rom_addr_q;
    rom_sel_d  = iss_vld ? iss_rom  : rom_sel_q;

    tag_vld_d = {tag_vld_q[RD_LAT-1:0], iss_vld};
    tag_idx_d = {tag_idx_q[RD_LAT-1:0], iss_idx};

    drv_data_d  = drv_data_q;
    drv_valid_d = '0;
    for (int i = 0; i < NDR; i++) begin
      if (tag_vld_q[RD_LAT] && tag_idx_q[RD_LAT] == PW'(i)) begin
        drv_data_d[i*8 +: 8] = rom_q;
        drv_valid_d[i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      ovr_q       <= '0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      drv_data_q  <= '0;
      drv_valid_q <= '0;
    end else begin
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      ovr_q       <= ovr_d;
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= rom_sel_d;
      drv_data_q  <= drv_data_d;
      drv_valid_q <= drv_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_sel   = rom_sel_q;
  assign drv_data  = drv_data_q;
  assign drv_valid = drv_valid_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// Bench for iecdrv_rom_sched: directed scenarios with literal expectations,
// then randomized rounds, all checked every cycle against a round-level
// model of the scheduler and a functional ROM image.
module tb_iecdrv_rom_sched;

  localparam int NDR    = 4;
  localparam int AW     = 15;
  localparam int NROM   = 3;
  localparam int RD_LAT = 1;
  localparam int RSW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                  round_start = 1'b0;
  logic                  ovr_clr = 1'b0;
  logic [NDR-1:0]        drv_en = '0;
  logic [NDR*AW-1:0]     drv_addr = '0;
  logic [NDR*RSW-1:0]    drv_rom = '0;
  logic [NROM*AW-1:0]    size_mask = '0;
  logic [AW-1:0]         rom_addr;
  logic [RSW-1:0]        rom_sel;
  logic [7:0]            rom_q;
  logic [NDR*8-1:0]      drv_data;
  logic [NDR-1:0]        drv_valid;
  logic [NDR-1:0]        ovr;

  iecdrv_rom_sched #(.NDR(NDR), .AW(AW), .NROM(NROM), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .round_start(round_start),
    .drv_en(drv_en), .drv_addr(drv_addr), .drv_rom(drv_rom),
    .size_mask(size_mask), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .rom_q(rom_q), .drv_data(drv_data), .drv_valid(drv_valid),
    .ovr(ovr), .ovr_clr(ovr_clr)
  );

  // ---------------- ROM bank ----------------
  function automatic logic [7:0] rom_byte(input logic [RSW-1:0] sel, input logic [AW-1:0] a);
    if (int'(sel) >= NROM) return 8'hFF;
    return a[7:0] ^ {1'b0, a[14:8]} ^ (8'h35 * 8'(sel));
  endfunction

  logic [7:0] rom_pipe [RD_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_byte(rom_sel, rom_addr);
    for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int due; int idx; logic [7:0] val; } ret_t;
  ret_t exp_q[$];
  logic [NDR-1:0] m_pend, m_ovr, m_valid;
  logic [7:0]     m_data [NDR];
  logic [AW-1:0]  m_addr;
  logic [RSW-1:0] m_sel;
  int             m_rounds, m_edge;

  task automatic model_reset();
    exp_q.delete();
    m_pend = '0; m_ovr = '0; m_valid = '0;
    m_addr = '0; m_sel = '0;
    m_rounds = 0; m_edge = 0;
    for (int i = 0; i < NDR; i++) m_data[i] = 8'h00;
  endtask

  task automatic model_step();
    logic [NDR-1:0] left;
    int   start, j;
    bit   found;
    ret_t r;
    m_edge++;
    m_valid = '0;
    while (exp_q.size() > 0 && exp_q[0].due == m_edge) begin
      r = exp_q.pop_front();
      m_data[r.idx]  = r.val;
      m_valid[r.idx] = 1'b1;
    end
    left = m_pend;
    if (m_rounds > 0) begin
      // Round n (1-based) gives first priority to drive (n-1) mod NDR.
      start = (m_rounds - 1) % NDR;
      found = 1'b0;
      for (int k = 0; k < NDR; k++) begin
        j = (start + k) % NDR;
        if (!found && left[j]) begin
          found   = 1'b1;
          left[j] = 1'b0;
          m_sel   = drv_rom[j*RSW +: RSW];
          m_addr  = drv_addr[j*AW +: AW] & size_mask[(int'(m_sel) % NROM)*AW +: AW];
          exp_q.push_back('{due: m_edge + RD_LAT + 1, idx: j, val: rom_byte(m_sel, m_addr)});
        end
      end
    end
    if (round_start) begin
      m_ovr = (ovr_clr ? '0 : m_ovr) | left;
      left  = drv_en;
      m_rounds++;
    end else if (ovr_clr) begin
      m_ovr = '0;
    end
    m_pend = left;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int         obs_q[$];
  int         exp_o[$];
  int         vcnt [NDR];
  logic [AW-1:0] sel1_addr = '0;

  initial begin
    logic [NDR*8-1:0] exp_data;
    for (int i = 0; i < NDR; i++) vcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDR; i++) exp_data[i*8 +: 8] = m_data[i];
      chk("rom_addr",  64'(rom_addr),  64'(m_addr));
      chk("rom_sel",   64'(rom_sel),   64'(m_sel));
      chk("drv_data",  64'(drv_data),  64'(exp_data));
      chk("drv_valid", 64'(drv_valid), 64'(m_valid));
      chk("ovr",       64'(ovr),       64'(m_ovr));
      for (int i = 0; i < NDR; i++) begin
        if (drv_valid[i]) begin
          obs_q.push_back(i);
          vcnt[i]++;
        end
      end
      if (rom_sel == 2'd1) sel1_addr = rom_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse round_start, then idle so the next round opens gap edges later.
  task automatic round(input int gap, input logic clr = 1'b0);
    round_start = 1'b1;
    ovr_clr     = clr;
    tick(1);
    round_start = 1'b0;
    ovr_clr     = 1'b0;
    tick(gap - 1);
  endtask

  task automatic set_base();
    drv_en    = 4'b1111;
    drv_addr  = {15'h4003, 15'h3002, 15'h2001, 15'h1000};
    drv_rom   = '0;
    size_mask = {15'h7FFF, 15'h7FFF, 15'h7FFF};
  endtask

  task automatic clr_vcnt();
    for (int i = 0; i < NDR; i++) vcnt[i] = 0;
  endtask

  task automatic chk_order(input string name);
    chk({name, "_len"}, 64'(obs_q.size()), 64'(exp_o.size()));
    for (int i = 0; i < exp_o.size() && i < obs_q.size(); i++)
      chk(name, 64'(obs_q[i]), 64'(exp_o[i]));
  endtask

  task automatic chk_base_data(input string name);
    chk({name, "_d0"}, 64'(drv_data[7:0]),   64'h10);
    chk({name, "_d1"}, 64'(drv_data[15:8]),  64'h21);
    chk({name, "_d2"}, 64'(drv_data[23:16]), 64'h32);
    chk({name, "_d3"}, 64'(drv_data[31:24]), 64'h43);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    set_base();
    tick(3);
    chk("rst_rom_addr",  64'(rom_addr),  64'h0);
    chk("rst_rom_sel",   64'(rom_sel),   64'h0);
    chk("rst_drv_data",  64'(drv_data),  64'h0);
    chk("rst_drv_valid", 64'(drv_valid), 64'h0);
    chk("rst_ovr",       64'(ovr),       64'h0);
    reset_n = 1'b1;
    tick(1);

    // Rounds 1-2: full rotation, no overruns.
    obs_q.delete();
    round(8);
    round(8);
    tick(2);
    exp_o = '{0, 1, 2, 3, 1, 2, 3, 0};
    chk_order("order_r12");
    chk_base_data("data_r12");
    chk("ovr_r12", 64'(ovr), 64'h0);

    // Round 3: drive 2 on image 1 with an 8K mask.
    drv_rom[2*RSW +: RSW] = 2'd1;
    size_mask[1*AW +: AW] = 15'h1FFF;
    drv_addr[2*AW +: AW]  = 15'h7ABC;
    round(8);
    chk("mask_addr", 64'(sel1_addr), 64'h1ABC);
    chk("mask_data", 64'(drv_data[23:16]), 64'h93);
    set_base();

    // Round 4: only drives 0 and 2 participate.
    drv_en = 4'b0101;
    clr_vcnt();
    round(8);
    chk("en_v0", 64'(vcnt[0]), 64'd1);
    chk("en_v1", 64'(vcnt[1]), 64'd0);
    chk("en_v2", 64'(vcnt[2]), 64'd1);
    chk("en_v3", 64'(vcnt[3]), 64'd0);
    chk_base_data("data_r4");

    // Rounds 5-6: round 5 is cut after 3 edges, drive 3 is left pending.
    drv_en = 4'b1111;
    round(3);
    round(8);
    chk("ovr_short", 64'(ovr), 64'h8);

    // Rounds 7-8: overrun of drive 1 coincides with ovr_clr; set wins,
    // the older bit 3 is cleared.
    round(3);
    round(8, 1'b1);
    chk("ovr_clr_set", 64'(ovr), 64'h2);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("ovr_clr_only", 64'(ovr), 64'h0);

    // Rounds 9-10: round 10 opens on the edge drive 3 is issued.
    clr_vcnt();
    round(4);
    round(8);
    chk("coin_ovr", 64'(ovr), 64'h0);
    chk("coin_v3", 64'(vcnt[3]), 64'd2);

    // Round 11: reset while drive 2's fetch is in flight.
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    tick(1);
    chk("pre_rst_addr", 64'(rom_addr), 64'h3002);
    reset_n = 1'b0;
    clr_vcnt();
    tick(3);
    chk("inrst_valids", 64'(vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3]), 64'd0);
    chk("inrst_data", 64'(drv_data), 64'h0);
    chk("inrst_addr", 64'(rom_addr), 64'h0);
    chk("inrst_ovr",  64'(ovr),      64'h0);
    reset_n = 1'b1;
    tick(1);
    obs_q.delete();
    round(8);
    tick(2);
    exp_o = '{0, 1, 2, 3};
    chk_order("order_post_rst");
    chk_base_data("data_post_rst");

    // Randomized rounds: random masks, images (incl. open-bus select 3),
    // addresses changing mid-round, random gaps and clears.
    for (int r = 0; r < 60; r++) begin
      drv_en = NDR'($urandom);
      for (int k = 0; k < NROM; k++) begin
        case ($urandom_range(0, 3))
          0: size_mask[k*AW +: AW] = 15'h7FFF;
          1: size_mask[k*AW +: AW] = 15'h3FFF;
          2: size_mask[k*AW +: AW] = 15'h1FFF;
          default: size_mask[k*AW +: AW] = AW'($urandom);
        endcase
      end
      for (int i = 0; i < NDR; i++) begin
        drv_addr[i*AW +: AW]  = AW'($urandom);
        drv_rom[i*RSW +: RSW] = RSW'($urandom_range(0, 3));
      end
      gap = $urandom_range(2, 10);
      round_start = 1'b1;
      ovr_clr     = ($urandom_range(0, 3) == 0);
      tick(1);
      round_start = 1'b0;
      for (int g = 1; g < gap; g++) begin
        ovr_clr = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1)
          drv_addr[$urandom_range(0, NDR-1)*AW +: AW] = AW'($urandom);
        tick(1);
      end
      ovr_clr = 1'b0;
    end
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
